fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests feeding a small FIFO.
// Optional backward-taken branch prediction via FETCH_BTFN_PREDICT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        fd_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        chng2nop,
  output logic        fetch_stall
);

  localparam int AW = (BUF_DEPTH > 2) ? 2 : 1;
  localparam logic [AW:0] DEPTH = (AW+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    FLUSH
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   next_pc;
  logic [31:0]   buf_instr [BUF_DEPTH];
  logic [31:0]   buf_pc    [BUF_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          c2n;
  logic          push;
  logic          pop;
  logic          unused_bits;

`ifdef FETCH_BTFN_PREDICT_EN
  logic [31:0] b_imm;
  logic        btfn;
  assign b_imm = {{20{imem_rdata[31]}}, imem_rdata[7],
                  imem_rdata[30:25], imem_rdata[11:8], 1'b0};
  assign btfn  = (imem_rdata[6:0] == 7'b1100011) && imem_rdata[31];
  assign next_pc = btfn ? fetch_pc + b_imm : fetch_pc + 32'd4;
`else
  assign next_pc = fetch_pc + 32'd4;
`endif

  assign unused_bits = ^{redirect_pc[1:0], next_pc[1:0]};

  assign push = (state == WAIT) && imem_rvalid && !redirect_valid;
  assign pop  = fd_en && instr_valid && !redirect_valid;

  assign instr_valid = (count != '0);
  assign fetch_stall = !instr_valid;
  assign instr_out   = instr_valid ? buf_instr[rd_ptr] : 32'h0000_0013;
  assign pc_out      = instr_valid ? buf_pc[rd_ptr] : fetch_pc;
  assign imem_req    = (state == REQ);
  assign imem_addr   = {fetch_pc[31:2], 2'b00};
  assign chng2nop    = c2n;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      c2n      <= 1'b0;
    end else begin
      state <= state_nxt;
      c2n   <= redirect_valid;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          fetch_pc <= {next_pc[31:2], 2'b00};
          wr_ptr   <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

  // Entry PC is the request PC: fetch_pc only moves on push.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]    <= fetch_pc;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!redirect_valid && count < DEPTH) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          state_nxt = imem_ack ? FLUSH : IDLE;
        end else if (imem_ack) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A response landing with the redirect is itself the discard.
        if (redirect_valid) begin
          state_nxt = imem_rvalid ? IDLE : FLUSH;
        end else if (imem_rvalid) begin
          state_nxt = IDLE;
        end
      end
      FLUSH: begin
        if (imem_rvalid) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model plus scoreboard of fetched {pc, instr}.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        nrst;
  logic        fd_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        chng2nop;
  logic        fetch_stall;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .BUF_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .fd_en         (fd_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid),
    .chng2nop      (chng2nop),
    .fetch_stall   (fetch_stall)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] sb[$];
  logic [63:0] ent;
  logic [31:0] exp_addr;
  logic [31:0] paddr;
  logic [31:0] last_addr;
  logic [31:0] redir_tgt;
  logic        exp_c2n;
  logic        pend;
  logic        squash;
  logic        redir_go;
  logic        fd_ctl;
  logic        fd_rand;
  logic        ack_rand;
  logic        lat_rand;
  int          lat;
  int          cnt;
  int          n_acks;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'hFE00_0EE3;
    return a ^ 32'h1357_0000;
  endfunction

  function automatic logic [31:0] pred_next(input logic [31:0] a);
`ifdef FETCH_BTFN_PREDICT_EN
    logic [31:0] w;
    w = mem_word(a);
    if (w[6:0] == 7'b1100011 && w[31])
      return (a + {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0})
             & 32'hFFFF_FFFC;
`endif
    return a + 32'd4;
  endfunction

  // All DUT inputs are driven here on the falling edge.
  always @(negedge clk) begin
    fd_en          = fd_rand ? 1'($urandom_range(0, 1)) : fd_ctl;
    redirect_valid = nrst && redir_go;
    redirect_pc    = redir_tgt;
    redir_go       = 1'b0;
    imem_ack       = 1'b0;
    imem_rvalid    = 1'b0;
    if (nrst) begin
      chk("chng2nop", 32'(chng2nop), 32'(exp_c2n));
      chk("valid", 32'(instr_valid), 32'(sb.size() != 0));
      chk("stall", 32'(fetch_stall), 32'(sb.size() == 0));
      if (!instr_valid) chk("nop", instr_out, 32'h0000_0013);
      if (fd_en && instr_valid && !redirect_valid && sb.size() != 0) begin
        ent = sb.pop_front();
        chk("pc_out", pc_out, ent[63:32]);
        chk("instr_out", instr_out, ent[31:0]);
      end
    end
    if (pend) begin
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(paddr);
        if (nrst && !squash && !redirect_valid)
          sb.push_back({paddr, imem_rdata});
        pend   = 1'b0;
        squash = 1'b0;
      end else begin
        cnt--;
      end
    end
    if (nrst && imem_req && (!ack_rand || $urandom_range(0, 1) == 1)) begin
      imem_ack = 1'b1;
      chk("imem_addr", imem_addr, exp_addr);
      last_addr = imem_addr;
      n_acks++;
      pend     = 1'b1;
      cnt      = lat_rand ? int'($urandom_range(0, lat)) : lat;
      paddr    = imem_addr;
      exp_addr = pred_next(imem_addr);
    end
    if (redirect_valid) begin
      sb.delete();
      squash   = pend;
      exp_addr = {redirect_pc[31:2], 2'b00};
    end
    exp_c2n = redirect_valid;
    if (!nrst) begin
      sb.delete();
      exp_addr = RST_PC;
      exp_c2n  = 1'b0;
      squash   = pend;
      n_acks   = 0;
    end
  end

  task automatic wait_acks(input int n);
    int start;
    int t;
    start = n_acks;
    t = 0;
    while (n_acks < start + n && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("ack_timeout", 32'(n_acks >= start + n), 32'd1);
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    redir_tgt = tgt;
    redir_go  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    nrst = 1'b0; fd_ctl = 1'b1; fd_rand = 1'b0; ack_rand = 1'b0;
    lat_rand = 1'b0; lat = 0; cnt = 0; pend = 1'b0; squash = 1'b0;
    redir_go = 1'b0; redir_tgt = '0; exp_c2n = 1'b0; n_acks = 0;
    exp_addr = RST_PC; last_addr = '0; imem_rdata = '0;
    fd_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr_out, 32'h0000_0013);
    chk("rst_pc", pc_out, RST_PC);
    chk("rst_c2n", 32'(chng2nop), 32'd0);
    chk("rst_stall", 32'(fetch_stall), 32'd1);
    nrst = 1'b1;
    @(posedge clk); #1;
    chk("rel_valid0", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    chk("rel_valid1", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    chk("first_valid", 32'(instr_valid), 32'd1);
    chk("first_pc", pc_out, RST_PC);
    wait_acks(2);
    chk("third_addr", last_addr, 32'h0000_0108);
    repeat (10) @(posedge clk);

    fd_ctl = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("full_count", 32'(sb.size()), 32'(DEPTH));
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_valid", 32'(instr_valid), 32'd1);
    fd_ctl = 1'b1;
    repeat (20) @(posedge clk);

    fd_rand = 1'b1; ack_rand = 1'b1; lat_rand = 1'b1; lat = 2;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 24) == 0) begin
        redir_tgt = $urandom & 32'h0000_0FFF;
        redir_go  = 1'b1;
      end
    end
    @(posedge clk);

    fd_rand = 1'b0; fd_ctl = 1'b1; ack_rand = 1'b0; lat_rand = 1'b0;
    lat = 3;
    t = 0;
    while (!(pend && cnt > 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("wait_found", 32'(pend && cnt > 0), 32'd1);
    redirect_to(32'h0000_0200);
    chk("c2n_pulse", 32'(chng2nop), 32'd1);
    chk("flush_valid", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    chk("c2n_end", 32'(chng2nop), 32'd0);
    wait_acks(1);
    chk("redir_addr", last_addr, 32'h0000_0200);
    lat = 0;
    repeat (10) @(posedge clk);

    redirect_to(32'h0000_0202);
    wait_acks(1);
    chk("redir_align", last_addr, 32'h0000_0200);

    redirect_to(32'hFFFF_FFFC);
    wait_acks(2);
    chk("wrap_addr", last_addr, 32'h0000_0000);

    redirect_to(32'h0000_0040);
    wait_acks(2);
`ifdef FETCH_BTFN_PREDICT_EN
    chk("btfn_addr", last_addr, 32'h0000_003C);
`else
    chk("btfn_addr", last_addr, 32'h0000_0044);
`endif
    repeat (20) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
